// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the serial window-statistics path.
//   PIX_W         : pixel width in bits
//   WIN_AREA_MAX  : largest window area whose sum still fits the 11-bit wsum
//                   of the downstream accumulator at the maximum pixel value 7
//   state_t       : window feeder FSM states
//   is_pow2()     : helper for elaboration-time parameter checks
// -----------------------------------------------------------------------------
package calc_pkg;

    localparam int PIX_W        = 3;
    localparam int WIN_AREA_MAX = 292;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/calc_serial_windowaddr.sv
// -----------------------------------------------------------------------------
// calc_serial_windowaddr
// Address generator for the window feeder. Clamps the requested origin so the
// window lies fully inside the image, then walks the window row-major using a
// row-base register (advanced by IMG_W per row) plus a column counter.
//   clk, reset : clock and asynchronous active-low reset
//   load       : latch the clamped origin and restart the walk
//   step       : advance to the next pixel (held once the last pixel is hit)
//   x0, y0     : requested window origin
//   addr       : current pixel address = row base + column
//   last       : current address is the final pixel of the window
// -----------------------------------------------------------------------------
module calc_serial_windowaddr
    import calc_pkg::*;
#(
    parameter int WIN_W  = 16,
    parameter int WIN_H  = 16,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic                     step,
    input  logic [$clog2(IMG_W)-1:0] x0,
    input  logic [$clog2(IMG_H)-1:0] y0,
    output logic [ADDR_W-1:0]        addr,
    output logic                     last
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int CW = (WIN_W > 1) ? $clog2(WIN_W) : 1;
    localparam int RW = (WIN_H > 1) ? $clog2(WIN_H) : 1;

    localparam logic [XW-1:0]     X_MAX    = XW'(IMG_W - WIN_W);
    localparam logic [YW-1:0]     Y_MAX    = YW'(IMG_H - WIN_H);
    localparam logic [CW-1:0]     COL_LAST = CW'(WIN_W - 1);
    localparam logic [RW-1:0]     ROW_LAST = RW'(WIN_H - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

    logic [XW-1:0]     xs;
    logic [YW-1:0]     ys;
    logic [ADDR_W-1:0] start_base;
    logic [ADDR_W-1:0] row_base;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic              col_wrap;

    // Clamp so the window never extends past the right or bottom edge.
    assign xs = (x0 > X_MAX) ? X_MAX : x0;
    assign ys = (y0 > Y_MAX) ? Y_MAX : y0;

    // IMG_W is a power of two, so ys*IMG_W + xs is plain bit concatenation.
    assign start_base = ADDR_W'({ys, xs});

    assign col_wrap = (col == COL_LAST);
    assign last     = col_wrap && (row == ROW_LAST);
    assign addr     = row_base + ADDR_W'(col);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_base <= '0;
            col      <= '0;
            row      <= '0;
        end else if (load) begin
            row_base <= start_base;
            col      <= '0;
            row      <= '0;
        end else if (step && !last) begin
            if (col_wrap) begin
                col      <= '0;
                row      <= row + RW'(1);
                row_base <= row_base + ROW_STEP;
            end else begin
                col <= col + CW'(1);
            end
        end
    end

endmodule

// File: rtl/calc_serial_windowfeed.sv
// -----------------------------------------------------------------------------
// calc_serial_windowfeed
// Producer side of the serial window-statistics path. A start pulse clears the
// downstream accumulator for one cycle, then reads a WIN_W x WIN_H window out
// of a synchronous-read image memory row-major, one pixel per cycle, and feeds
// each returned pixel to the accumulator. done pulses in the first cycle in
// which the accumulator totals are final (start-to-done latency N+3).
//   clk, reset : clock and asynchronous active-low reset
//   start      : request pulse, honoured only in IDLE
//   x0, y0     : requested window origin, sampled with start
//   busy       : window in progress (CLEAR, READ, DRAIN)
//   done       : one-cycle pulse, accumulator totals final
//   mem_addr   : pixel address row*IMG_W + col
//   mem_rd     : read strobe, data valid on mem_data one cycle later
//   mem_data   : pixel read data
//   wclr_n     : registered active-low accumulator clear
//   wdata      : pixel to accumulator (zero while wable is low)
//   wable      : accumulate enable (mem_rd delayed one cycle)
// -----------------------------------------------------------------------------
module calc_serial_windowfeed
    import calc_pkg::*;
#(
    parameter int WIN_W  = 16,
    parameter int WIN_H  = 16,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [$clog2(IMG_W)-1:0] x0,
    input  logic [$clog2(IMG_H)-1:0] y0,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     mem_rd,
    input  logic [PIX_W-1:0]         mem_data,
    output logic                     wclr_n,
    output logic [PIX_W-1:0]         wdata,
    output logic                     wable
);

    // Elaboration-time parameter checks.
    if (WIN_W * WIN_H > WIN_AREA_MAX) begin : g_area_check
        $error("window area %0d exceeds accumulator limit %0d", WIN_W * WIN_H, WIN_AREA_MAX);
    end
    if (!is_pow2(IMG_W)) begin : g_img_w_check
        $error("IMG_W %0d must be a power of two", IMG_W);
    end
    if ((WIN_W > IMG_W) || (WIN_H > IMG_H)) begin : g_fit_check
        $error("window %0dx%0d larger than image %0dx%0d", WIN_W, WIN_H, IMG_W, IMG_H);
    end
    if (IMG_W * IMG_H > (2 ** ADDR_W)) begin : g_addr_check
        $error("image does not fit in %0d address bits", ADDR_W);
    end

    state_t state;
    state_t next_state;
    logic   load;
    logic   last;

    calc_serial_windowaddr #(
        .WIN_W  (WIN_W),
        .WIN_H  (WIN_H),
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .step   (mem_rd),
        .x0     (x0),
        .y0     (y0),
        .addr   (mem_addr),
        .last   (last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        mem_rd     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                busy       = 1'b1;
                next_state = ST_READ;
            end
            ST_READ: begin
                busy   = 1'b1;
                mem_rd = 1'b1;
                if (last) begin
                    next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy       = 1'b1;
                next_state = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // wclr_n is registered from the next state so it is low exactly during
    // CLEAR; wable trails mem_rd by the one-cycle memory read latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wclr_n <= 1'b1;
            wable  <= 1'b0;
        end else begin
            wclr_n <= (next_state != ST_CLEAR);
            wable  <= mem_rd;
        end
    end

    assign wdata = wable ? mem_data : '0;

endmodule

// File: doc/calc_serial_windowfeed.md
# calc_serial_windowfeed

Producer side of the serial window-statistics path. On a start pulse it clears the downstream window accumulator, then walks a WIN_W x WIN_H window of 3-bit pixels out of a synchronous-read image memory in row-major order, presenting one pixel per cycle on the `wdata`/`wable` interface that the accumulator consumes. It flags `done` in the first cycle in which the accumulator's `wsum`/`w2sum` hold the final window totals.

## Interface
- WIN_W, 16, window width in pixels
- WIN_H, 16, window height in pixels; WIN_W*WIN_H ≤ 292 (11-bit wsum limit at max pixel 7)
- IMG_W, 64, image width in pixels
- IMG_H, 64, image height in pixels
- ADDR_W, 12, memory address width; IMG_W*IMG_H ≤ 2^ADDR_W
- clk  in  1  single clock, all logic on posedge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request pulse, sampled only in IDLE
- x0  in  clog2(IMG_W)  window left column, sampled with start
- y0  in  clog2(IMG_H)  window top row, sampled with start
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle pulse: accumulator totals final
- mem_addr  out  ADDR_W  pixel address = row*IMG_W + col
- mem_rd  out  1  read strobe; data returns on mem_data the next cycle
- mem_data  in  3  pixel read data
- wclr_n  out  1  active-low clear to the accumulator reset input, registered
- wdata  out  3  pixel to accumulator
- wable  out  1  accumulate enable

## Operation
- FSM states: IDLE, CLEAR, READ, DRAIN, DONE.
- IDLE: start=1 latches the clamped origin. Next state is CLEAR. start is ignored in every other state.
- Origin clamping: xs = min(x0, IMG_W-WIN_W) and ys = min(y0, IMG_H-WIN_H). The window is never partially outside the image.
- CLEAR: one cycle with wclr_n=0. Next state is READ.
- READ: exactly N = WIN_W*WIN_H cycles with mem_rd=1.
  - Addresses run row-major from ys*IMG_W+xs.
  - The column counter c runs 0..WIN_W-1. When it wraps, the row base advances by IMG_W.
  - After the last address, next state is DRAIN.
- wable is mem_rd delayed one cycle. wdata = mem_data while wable=1, otherwise 0.
- DRAIN: one cycle, carries the last wable. Next state is DONE.
- DONE: done=1 for one cycle. Next state is IDLE.
- Addresses are formed with incremental adders only (row base plus column). No multiplier in the address path.

## Timing
- Reset values: busy=0, done=0, mem_rd=0, mem_addr=0, wable=0, wdata=0, wclr_n=1. FSM state is IDLE.
- Cycle numbering: start is accepted at edge E0.
  - CLEAR: cycle 1 (busy=1, wclr_n=0).
  - READ: cycles 2..N+1.
  - wable: cycles 3..N+2.
  - DONE: cycle N+3 (done=1, busy=0).
  - Start-to-done latency is N+3 cycles.
- The earliest next start is sampled in cycle N+4 (back in IDLE). A start asserted during the DONE cycle is dropped.
- Mid-operation reset: all outputs return to reset values immediately. No partial done. The accumulator state is a don't-care and is cleared by the next CLEAR.
- wable is never high in the CLEAR cycle. The accumulator sees exactly N enables per window.

## Structure
- Shared package calc_pkg holds:
  - the FSM state enum;
  - constant PIX_W=3;
  - the WIN_W*WIN_H ≤ 292 limit, checked by an elaboration-time assertion.
- One sub-module: calc_serial_windowaddr. It holds the row/column counters, the row-base adder, the clamp logic and the last-pixel flag. The FSM and the wable/wdata pipeline live in the top.

## Test plan
- Memory preloaded with pixel(x,y) = (x+y)%8. start with x0=0, y0=0, WIN 4x4, IMG 8x8:
  - wable high for 16 cycles;
  - done at cycle 19;
  - accumulator wsum=48, w2sum=184.
- Memory all 7s, WIN 16x16:
  - 256 enables;
  - final wsum=1792, w2sum=12544;
  - no overflow.
- x0=62, y0=63 with IMG 64x64, WIN 16x16:
  - origin clamps to (48,48);
  - first mem_addr=3120, last=4095.
- start held high for 40 cycles: exactly one window runs, and a second window begins only after the DONE cycle.
- reset pulled low at cycle 8 of READ:
  - busy, mem_rd, wable and done go to 0 in that same cycle;
  - a new start then yields correct totals.
- Back-to-back windows, with start asserted in the first IDLE cycle: wclr_n pulses low before the second window, and the second totals are independent of the first.
